// File: rtl/addbit_pkg.sv
// Shared helpers for the pipelined chunked adder: reference chunk adder and
// parameter legality check used at elaboration.
package addbit_pkg;

  localparam int MAX_CHUNK = 64;

  // Returns {carry_out, sum}; callers zero-extend narrower chunks, so the
  // carry lands at bit position CHUNK of the result.
  function automatic logic [MAX_CHUNK:0] chunk_add(
    input logic [MAX_CHUNK-1:0] a,
    input logic [MAX_CHUNK-1:0] b,
    input logic                 ci
  );
    return {1'b0, a} + {1'b0, b} + {{MAX_CHUNK{1'b0}}, ci};
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0) && ((width / stages) <= MAX_CHUNK);
  endfunction

endpackage

// File: rtl/addbit_slice.sv
// Combinational W-bit ripple adder made of chained full-adder (addbit) cells.
module addbit_slice
  import addbit_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  logic                 carry;
  logic [MAX_CHUNK:0]   ref_sum;

  always_comb begin
    carry = ci_i;
    s_o   = '0;
    for (int i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    co_o = carry;
  end

  // The ripple chain must agree with the plain arithmetic reference.
  always_comb begin
    ref_sum = chunk_add(MAX_CHUNK'(a_i), MAX_CHUNK'(b_i), ci_i);
    assert (ref_sum == (MAX_CHUNK + 1)'({co_o, s_o}));
  end

endmodule

// File: rtl/addbit_pipe.sv
// WIDTH-bit adder whose carry chain is cut into STAGES registered chunks,
// with a valid/ready pipeline that collapses bubbles.
module addbit_pipe
  import addbit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;

  if (!params_legal(WIDTH, STAGES)) begin : g_param_err
    $error("addbit_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Handshake: a beat moves on every edge where valid & ready are both high;
  // stage k is ready when it is empty or the stage after it is ready, so
  // in_ready follows out_ready combinationally through the chain.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_q, v_d, c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             v_in, c_in;
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;
    logic             rdy;
    logic             rdy_next;

    if (k == 0) begin : g_src
      assign v_in = in_valid;
      assign a_in = a;
      assign b_in = b;
      assign c_in = ci;
      assign s_in = '0;
    end else begin : g_src
      assign v_in = g_stage[k-1].v_q;
      assign a_in = g_stage[k-1].a_q;
      assign b_in = g_stage[k-1].b_q;
      assign c_in = g_stage[k-1].c_q;
      assign s_in = g_stage[k-1].s_q;
    end

    if (k == STAGES - 1) begin : g_rdy
      assign rdy_next = out_ready;
    end else begin : g_rdy
      assign rdy_next = g_stage[k+1].rdy;
    end

    assign rdy = !v_q || rdy_next;

    addbit_slice #(.W(CHUNK)) u_slice (
      .a_i  (a_in[k*CHUNK +: CHUNK]),
      .b_i  (b_in[k*CHUNK +: CHUNK]),
      .ci_i (c_in),
      .s_o  (chunk_s),
      .co_o (chunk_c)
    );

    always_comb begin
      v_d = v_q;
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      s_d = s_q;
      if (rdy) begin
        v_d = v_in;
        a_d = a_in;
        b_d = b_in;
        c_d = chunk_c;
        s_d = s_in;
        s_d[k*CHUNK +: CHUNK] = chunk_s;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        a_q <= a_d;
        b_q <= b_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign co        = g_stage[STAGES-1].c_q;
  // Signed overflow: like-signed operands yielding a result of the other sign.
  assign ovf       = (g_stage[STAGES-1].a_q[MSB] == g_stage[STAGES-1].b_q[MSB]) &&
                     (g_stage[STAGES-1].s_q[MSB] != g_stage[STAGES-1].a_q[MSB]);

endmodule

// File: tb/tb_addbit_pipe.sv
// Bench for addbit_pipe: directed handshake/reset scenarios on an 8/2 instance
// plus randomized scoreboard runs on several WIDTH/STAGES configurations.
module tb_addbit_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main 8/2 instance ----------------
  logic       rst_n, in_valid, in_ready, ci, out_valid, out_ready, co, ovf;
  logic [7:0] a, b, sum;

  addbit_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  logic [9:0] exp_q[$];
  int         acc_q[$];

  // Reference: {ovf, co, sum} from plain integer addition.
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned t;
    logic [7:0]  s;
    t = int'(x) + int'(y) + int'(c);
    s = t[7:0];
    return {(x[7] == y[7]) && (s[7] != x[7]), t[8], s};
  endfunction

  task automatic send_exp(input logic [7:0] ta, input logic [7:0] tb_, input logic tci,
                          input logic [9:0] e, output int waited);
    bit got;
    tick();
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    ci = tci;
    waited = 0;
    got = 1'b0;
    while (!got && waited <= 50) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        got = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!got) chk("send_timeout", 1, 0);
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic tci, output int waited);
    send_exp(ta, tb_, tci, model8(ta, tb_, tci), waited);
  endtask

  // ---------------- monitor for main instance ----------------
  bit head_new0   = 1'b1;
  int last_stall0 = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      head_new0 = 1'b1;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 0);
        end else begin
          if (head_new0) begin
            chk("latency_min", 64'((cyc - acc_q[0]) >= 2), 1);
            if (last_stall0 < acc_q[0]) chk("latency", 64'(cyc - acc_q[0]), 2);
          end
          chk("result", {ovf, co, sum}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      head_new0 = !out_valid || out_ready;
      if (!out_ready) last_stall0 = cyc;
    end
  end

  // ---------------- sweep instances ----------------
  logic sw_rst_n  = 1'b0;
  bit   sweep_go  = 1'b0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int W = (gi == 0) ? 1 : (gi == 1) ? 8 : (gi == 2) ? 8 : 32;
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 1 : (gi == 2) ? 8 : 4;

    logic         iv, ir, sci, ov, ordy, sco, sovf;
    logic [W-1:0] sa, sb, ss;
    logic [W+1:0] q[$];
    int           aq[$];
    bit           done       = 1'b0;
    bit           head_new   = 1'b1;
    int           last_stall = -1;

    addbit_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (sw_rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (sa),
      .b         (sb),
      .ci        (sci),
      .out_valid (ov),
      .out_ready (ordy),
      .sum       (ss),
      .co        (sco),
      .ovf       (sovf)
    );

    function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c);
      logic [W:0] full;
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      return {(x[W-1] == y[W-1]) && (full[W-1] != x[W-1]), full};
    endfunction

    initial begin
      int sent;
      bit took;
      sent = 0;
      took = 1'b0;
      iv   = 1'b0;
      sa   = '0;
      sb   = '0;
      sci  = 1'b0;
      ordy = 1'b0;
      wait (sweep_go);
      while (sent < 1000) begin
        tick();
        if (!iv || took) begin
          iv  = ($urandom_range(0, 3) != 0);
          sa  = W'($urandom);
          sb  = W'($urandom);
          sci = 1'($urandom);
        end
        ordy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        took = iv && ir;
        if (took) begin
          q.push_back(ref_model(sa, sb, sci));
          aq.push_back(cyc);
          sent++;
        end
      end
      tick();
      iv   = 1'b0;
      ordy = 1'b1;
      for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
      chk($sformatf("sweep%0d_drained", gi), 64'(q.size()), 0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (!sweep_go || !sw_rst_n) begin
        head_new = 1'b1;
      end else begin
        if (ov) begin
          if (q.size() == 0) begin
            chk($sformatf("sweep%0d_unexpected_out", gi), 64'(ov), 0);
          end else begin
            if (head_new) begin
              chk($sformatf("sweep%0d_latency_min", gi), 64'((cyc - aq[0]) >= S), 1);
              if (last_stall < aq[0])
                chk($sformatf("sweep%0d_latency", gi), 64'(cyc - aq[0]), 64'(S));
            end
            chk($sformatf("sweep%0d_result", gi), {sovf, sco, ss}, q[0]);
            if (ordy) begin
              void'(q.pop_front());
              void'(aq.pop_front());
            end
          end
        end
        head_new = !ov || ordy;
        if (!ordy) last_stall = cyc;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int n_acc;
    bit took;
    int t;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h55;
    b         = 8'hAA;
    ci        = 1'b1;
    out_ready = 1'b1;

    // Reset with in_valid asserted
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_sum", 64'(sum), 0);
      chk("rst_co", 64'(co), 0);
      chk("rst_ovf", 64'(ovf), 0);
    end
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 1);

    // Streaming with known answers
    send_exp(8'h0F, 8'h01, 1'b0, 10'h010, w);
    send_exp(8'hFF, 8'h01, 1'b0, 10'h100, w);
    send_exp(8'h7F, 8'h01, 1'b0, 10'h280, w);
    send_exp(8'h80, 8'h80, 1'b1, 10'h301, w);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stream_drained", 64'(exp_q.size()), 0);

    // Stall under continuous in_valid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      took = in_ready;
      if (took) begin
        exp_q.push_back(model8(a, b, ci));
        acc_q.push_back(cyc);
        n_acc++;
      end
      tick();
      if (took) begin
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      end
    end
    chk("stall_accepted", 64'(n_acc), 2);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("stall_drained", 64'(exp_q.size()), 0);

    // Bubble collapse while output stalled
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, w);
    chk("bubble_first_wait", 64'(w), 0);
    tick();
    in_valid = 1'b0;
    send(8'hC3, 8'h5A, 1'b1, w);
    chk("bubble_accept_wait", 64'(w), 0);
    tick();
    a = 8'h01; b = 8'h02; ci = 1'b0;
    @(negedge clk);
    chk("bubble_full_in_ready", 64'(in_ready), 0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("bubble_drained", 64'(exp_q.size()), 0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(8'hA0, 8'h0B, 1'b0, w);
    send(8'h44, 8'h44, 1'b1, w);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("inflight_out_valid", 64'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 0);
    chk("midreset_sum", 64'(sum), 0);
    chk("midreset_co", 64'(co), 0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 64'(out_valid), 0);
    end

    // Randomized parameter sweep
    tick();
    sw_rst_n = 1'b1;
    sweep_go = 1'b1;
    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    chk("sweep_finished", 64'(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
